// File: rtl/sequence_gen.sv
// Serial pattern source: valid/ready load, repeated MSB-first frames with idle gaps.
// Define SEQ_GEN_LSB_FIRST_EN to shift frames LSB first instead.
module sequence_gen #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pat_valid,
    input  logic [WIDTH-1:0] pat_data,
    input  logic [3:0]       pat_rep,
    output logic             pat_ready,
    input  logic             abort,
    output logic             a,
    output logic             a_valid,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [3:0]       rep_q, rep_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [3:0]       gap_q, gap_d;
    logic             a_q, a_d;
    logic             av_q, av_d;
    logic             done_q, done_d;

    // sh_q holds the bits still to come after the one currently on a_q
    function automatic logic first_bit(input logic [WIDTH-1:0] v);
`ifdef SEQ_GEN_LSB_FIRST_EN
        return v[0];
`else
        return v[WIDTH-1];
`endif
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
`ifdef SEQ_GEN_LSB_FIRST_EN
        return v >> 1;
`else
        return v << 1;
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            pat_q   <= '0;
            rep_q   <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            a_q     <= 1'b0;
            av_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            pat_q   <= pat_d;
            rep_q   <= rep_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            a_q     <= a_d;
            av_q    <= av_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        pat_d   = pat_q;
        rep_d   = rep_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        a_d     = 1'b0;
        av_d    = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pat_valid) begin
                    state_d = S_SHIFT;
                    pat_d   = pat_data;
                    rep_d   = pat_rep;
                    sh_d    = advance(pat_data);
                    bit_d   = '0;
                    gap_d   = '0;
                    a_d     = first_bit(pat_data);
                    av_d    = 1'b1;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    sh_d    = '0;
                    rep_d   = '0;
                    bit_d   = '0;
                    gap_d   = '0;
                end else if (bit_q == BIT_LAST) begin
                    bit_d = '0;
                    if (rep_q == 4'd0) begin
                        state_d = S_IDLE;
                        sh_d    = '0;
                        done_d  = 1'b1;
                    end else begin
                        rep_d = rep_q - 4'd1;
                        if (GAP > 0) begin
                            state_d = S_GAP;
                            gap_d   = '0;
                            sh_d    = pat_q;
                        end else begin
                            a_d  = first_bit(pat_q);
                            av_d = 1'b1;
                            sh_d = advance(pat_q);
                        end
                    end
                end else begin
                    bit_d = bit_q + BW'(1);
                    a_d   = first_bit(sh_q);
                    av_d  = 1'b1;
                    sh_d  = advance(sh_q);
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                    sh_d    = '0;
                    rep_d   = '0;
                    bit_d   = '0;
                    gap_d   = '0;
                end else if (gap_q == GAP_LAST) begin
                    state_d = S_SHIFT;
                    gap_d   = '0;
                    a_d     = first_bit(sh_q);
                    av_d    = 1'b1;
                    sh_d    = advance(sh_q);
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pat_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign a         = a_q;
    assign a_valid   = av_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sequence_gen.sv
// Self-checking bench for sequence_gen: GAP=2 and GAP=0 instances
// against a frame-list reference model.
module tb_sequence_gen;

    localparam int W = 8;

    logic clk;
    logic rst_n;

    logic         pv, ab, rdy, a, av, bsy, dn;
    logic [W-1:0] pd;
    logic [3:0]   pr;

    logic         pv0, ab0, rdy0, a0, av0, bsy0, dn0;
    logic [W-1:0] pd0;
    logic [3:0]   pr0;

    int checks;
    int failures;

    logic exp_a[$];
    logic exp_v[$];

    sequence_gen #(.WIDTH(W), .GAP(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pat_valid (pv),
        .pat_data  (pd),
        .pat_rep   (pr),
        .pat_ready (rdy),
        .abort     (ab),
        .a         (a),
        .a_valid   (av),
        .busy      (bsy),
        .done      (dn)
    );

    sequence_gen #(.WIDTH(W), .GAP(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .pat_valid (pv0),
        .pat_data  (pd0),
        .pat_rep   (pr0),
        .pat_ready (rdy0),
        .abort     (ab0),
        .a         (a0),
        .a_valid   (av0),
        .busy      (bsy0),
        .done      (dn0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected (a, a_valid) per busy cycle: frames of W bits with gap zeros between
    function automatic void build(input logic [W-1:0] d, input int rep, input int gap);
        exp_a.delete();
        exp_v.delete();
        for (int f = 0; f <= rep; f++) begin
            for (int i = 0; i < W; i++) begin
`ifdef SEQ_GEN_LSB_FIRST_EN
                exp_a.push_back(d[i]);
`else
                exp_a.push_back(d[W-1-i]);
`endif
                exp_v.push_back(1'b1);
            end
            if (f < rep) begin
                for (int g = 0; g < gap; g++) begin
                    exp_a.push_back(1'b0);
                    exp_v.push_back(1'b0);
                end
            end
        end
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({rdy, a, av, bsy, dn} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=10000", {rdy, a, av, bsy, dn});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_frame(input string name, input logic [W-1:0] d, input int rep);
        build(d, rep, 2);
        @(negedge clk);
        pv = 1'b1;
        pd = d;
        pr = rep[3:0];
        @(negedge clk);
        pv = 1'b0;
        for (int i = 0; i < exp_a.size(); i++) begin
            if (i > 0) @(negedge clk);
            pd = 8'($urandom());
            pr = 4'($urandom());
            checks++;
            if ({a, av} !== {exp_a[i], exp_v[i]}) begin
                failures++;
                $display("FAIL %s_bit%0d a/av got=%b%b exp=%b%b",
                         name, i, a, av, exp_a[i], exp_v[i]);
            end
            checks++;
            if ({bsy, rdy, dn} !== 3'b100) begin
                failures++;
                $display("FAIL %s_busy%0d busy/ready/done got=%b exp=100",
                         name, i, {bsy, rdy, dn});
            end
        end
        @(negedge clk);
        checks++;
        if ({dn, rdy, bsy, av, a} !== 5'b11000) begin
            failures++;
            $display("FAIL %s_done done/ready/busy/av/a got=%b exp=11000",
                     name, {dn, rdy, bsy, av, a});
        end
        @(negedge clk);
        checks++;
        if (dn !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_pulse got=%b exp=0", name, dn);
        end
    endtask

    task automatic test_contiguous();
        build(8'hF0, 1, 0);
        @(negedge clk);
        pv0 = 1'b1;
        pd0 = 8'hF0;
        pr0 = 4'd1;
        @(negedge clk);
        pv0 = 1'b0;
        for (int i = 0; i < exp_a.size(); i++) begin
            if (i > 0) @(negedge clk);
            pd0 = 8'($urandom());
            checks++;
            if ({a0, av0, bsy0, dn0} !== {exp_a[i], 3'b110}) begin
                failures++;
                $display("FAIL contig_bit%0d a/av/busy/done got=%b exp=%b110",
                         i, {a0, av0, bsy0, dn0}, exp_a[i]);
            end
        end
        @(negedge clk);
        checks++;
        if ({dn0, rdy0, av0} !== 3'b110) begin
            failures++;
            $display("FAIL contig_done done/ready/av got=%b exp=110", {dn0, rdy0, av0});
        end
    endtask

    task automatic test_abort();
        build(8'hA5, 1, 2);
        @(negedge clk);
        pv = 1'b1;
        pd = 8'hA5;
        pr = 4'd1;
        ab = 1'b1;
        @(negedge clk);
        pv = 1'b0;
        ab = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({a, av} !== {exp_a[i], 1'b1}) begin
                failures++;
                $display("FAIL abort_bit%0d a/av got=%b%b exp=%b1", i, a, av, exp_a[i]);
            end
        end
        ab = 1'b1;
        @(negedge clk);
        ab = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if ({av, a, rdy, bsy, dn} !== 5'b00100) begin
                failures++;
                $display("FAIL abort_idle%0d av/a/ready/busy/done got=%b exp=00100",
                         i, {av, a, rdy, bsy, dn});
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        pv = 1'b1;
        pd = 8'hFF;
        pr = 4'd3;
        @(negedge clk);
        pv = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rdy, a, av, bsy, dn} !== 5'b10000) begin
            failures++;
            $display("FAIL async_reset ready/a/av/busy/done got=%b exp=10000",
                     {rdy, a, av, bsy, dn});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({rdy, av, dn} !== 3'b100) begin
            failures++;
            $display("FAIL post_reset_idle ready/av/done got=%b exp=100", {rdy, av, dn});
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            logic [W-1:0] d;
            int           rep;
            d   = 8'($urandom());
            rep = int'($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            test_frame($sformatf("rand%0d", t), d, rep);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        pv = 1'b0; pd = '0; pr = '0; ab = 1'b0;
        pv0 = 1'b0; pd0 = '0; pr0 = '0; ab0 = 1'b0;
        test_reset();
        test_frame("single", 8'b0111_0001, 0);
        test_frame("repeat_gap", 8'hA5, 2);
        test_contiguous();
        test_abort();
        test_frame("after_abort", 8'h5A, 0);
        test_async_reset();
        test_frame("after_reset", 8'h3C, 0);
        test_random();
        test_frame("back_to_back", 8'hC3, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
